// File: rtl/seq_det_pkg.sv
// Shared constants for the parameterised serial pattern detector.
package seq_det_pkg;

  // Default pattern length and the pattern loaded at reset
  localparam int unsigned DEF_PAT_W = 5;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 5'b10110;

  // Overlap-mode encoding of the overlap input
  localparam logic OVL_OFF = 1'b0;
  localparam logic OVL_ON  = 1'b1;

endpackage

// File: rtl/seq_detector_param_if.sv
// Control/data bundle of the pattern detector.
//   x, x_valid        : serial bit and its qualifier
//   overlap           : 1 = overlapping detection
//   pat_load, pat_in,
//   pat_len           : pattern reload strobe and payload (LSB = most recent bit)
//   cnt_clr           : synchronous match counter clear
//   out, match_cnt    : match pulse and saturating match count
interface seq_detector_param_if #(
  parameter int unsigned PAT_W = 5,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned LEN_W = $clog2(PAT_W + 1);

  logic             x;
  logic             x_valid;
  logic             overlap;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic [LEN_W-1:0] pat_len;
  logic             cnt_clr;
  logic             out;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output x, x_valid, overlap, pat_load, pat_in, pat_len, cnt_clr,
    input  out, match_cnt
  );

  modport slave (
    input  x, x_valid, overlap, pat_load, pat_in, pat_len, cnt_clr,
    output out, match_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear wins over a simultaneous increment.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear
//   inc      : increment request
//   cnt      : registered count, sticks at all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with runtime-loadable pattern/length,
// overlapping or non-overlapping detection and a saturating match count.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of seq_detector_param_if (stream, control, results)
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PATTERN),
  parameter int unsigned      CNT_W   = 8,
  parameter bit               MEALY   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_detector_param_if.slave  bus
);

  localparam int unsigned      LEN_W = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] FULL  = LEN_W'(PAT_W);

  logic [PAT_W-1:0] win;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] len;
  logic [PAT_W-1:0] win_nx;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill_nx;
  logic [LEN_W-1:0] len_in;
  logic             match_c;
  logic             out_q;

  // Post-shift window/fill and the match decision on the low len bits
  always_comb begin
    win_nx  = {win[PAT_W-2:0], bus.x};
    fill_nx = (fill >= FULL) ? FULL : fill + LEN_W'(1);
    mask    = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    match_c = bus.x_valid && !bus.pat_load && (fill_nx >= len) &&
              (((win_nx ^ pat) & mask) == '0);
  end

  // Out-of-range lengths fall back to the full window
  always_comb begin
    len_in = bus.pat_len;
    if ((bus.pat_len == '0) || (bus.pat_len > FULL)) begin
      len_in = FULL;
    end
  end

  // Window, fill, pattern and registered match pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win   <= '0;
      fill  <= '0;
      pat   <= DEF_PAT;
      len   <= FULL;
      out_q <= 1'b0;
    end else begin
      out_q <= match_c;
      if (bus.pat_load) begin
        pat  <= bus.pat_in;
        len  <= len_in;
        fill <= '0;
      end else if (bus.x_valid) begin
        win  <= win_nx;
        // Non-overlap restarts collection so matched bits are not reused
        fill <= (match_c && (bus.overlap == OVL_OFF)) ? '0 : fill_nx;
      end
    end
  end

  assign bus.out = MEALY ? match_c : out_q;

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.cnt_clr),
    .inc (match_c),
    .cnt (bus.match_cnt)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  logic       clk;
  logic       rst;
  logic       x, x_valid, overlap, pat_load, cnt_clr;
  logic [4:0] pat_in;
  logic [2:0] pat_len;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // a: Moore CNT_W=8, b: Mealy CNT_W=8, c: Moore CNT_W=2
  seq_detector_param_if #(.PAT_W(5), .CNT_W(8)) ifa ();
  seq_detector_param_if #(.PAT_W(5), .CNT_W(8)) ifb ();
  seq_detector_param_if #(.PAT_W(5), .CNT_W(2)) ifc ();

  assign ifa.x = x;  assign ifa.x_valid = x_valid; assign ifa.overlap = overlap;
  assign ifa.pat_load = pat_load; assign ifa.pat_in = pat_in; assign ifa.pat_len = pat_len;
  assign ifa.cnt_clr = cnt_clr;
  assign ifb.x = x;  assign ifb.x_valid = x_valid; assign ifb.overlap = overlap;
  assign ifb.pat_load = pat_load; assign ifb.pat_in = pat_in; assign ifb.pat_len = pat_len;
  assign ifb.cnt_clr = cnt_clr;
  assign ifc.x = x;  assign ifc.x_valid = x_valid; assign ifc.overlap = overlap;
  assign ifc.pat_load = pat_load; assign ifc.pat_in = pat_in; assign ifc.pat_len = pat_len;
  assign ifc.cnt_clr = cnt_clr;

  seq_detector_param #(.PAT_W(5), .CNT_W(8), .MEALY(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  seq_detector_param #(.PAT_W(5), .CNT_W(8), .MEALY(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  seq_detector_param #(.PAT_W(5), .CNT_W(2), .MEALY(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: history of accepted bits since the last restart
  bit         hist[$];
  logic [4:0] mpat;
  int         mlen;
  int         cnt_a;
  int         cnt_c;
  bit         m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    mpat  = 5'b10110;
    mlen  = 5;
    cnt_a = 0;
    cnt_c = 0;
  endtask

  function automatic bit model_match();
    bit b;
    if (!x_valid || pat_load) return 1'b0;
    if (hist.size() + 1 < mlen) return 1'b0;
    for (int i = 0; i < mlen; i++) begin
      b = (i == 0) ? x : hist[hist.size() - i];
      if (b != mpat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock: Mealy output checked mid-cycle, registered results after the edge
  task automatic cycle(input string tag);
    m = model_match();
    @(negedge clk);
    chk({tag, "/mealy_out"}, 32'(ifb.out), 32'(m));
    @(posedge clk);
    #1;
    if (pat_load) begin
      mpat = pat_in;
      mlen = (pat_len == 0 || pat_len > 5) ? 5 : int'(pat_len);
      hist.delete();
    end else if (x_valid) begin
      hist.push_back(x);
      if (hist.size() > 16) void'(hist.pop_front());
      if (m && !overlap) hist.delete();
    end
    if (cnt_clr) begin
      cnt_a = 0;
      cnt_c = 0;
    end else if (m) begin
      if (cnt_a < 255) cnt_a++;
      if (cnt_c < 3) cnt_c++;
    end
    chk({tag, "/moore_out"}, 32'(ifa.out), 32'(m));
    chk({tag, "/moore2_out"}, 32'(ifc.out), 32'(m));
    chk({tag, "/cnt_a"}, 32'(ifa.match_cnt), 32'(cnt_a));
    chk({tag, "/cnt_b"}, 32'(ifb.match_cnt), 32'(cnt_a));
    chk({tag, "/cnt_c"}, 32'(ifc.match_cnt), 32'(cnt_c));
  endtask

  task automatic bit_in(input logic b, input string tag);
    x = b; x_valid = 1'b1; pat_load = 1'b0; cnt_clr = 1'b0;
    cycle(tag);
    x_valid = 1'b0;
  endtask

  task automatic gap(input string tag);
    x = 1'b1; x_valid = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
    cycle(tag);
  endtask

  task automatic load(input logic [4:0] p, input logic [2:0] l, input string tag);
    pat_in = p; pat_len = l; pat_load = 1'b1; x_valid = 1'b1; x = 1'b1; cnt_clr = 1'b0;
    cycle(tag);
    pat_load = 1'b0; x_valid = 1'b0;
  endtask

  task automatic clear(input string tag);
    x_valid = 1'b0; pat_load = 1'b0; cnt_clr = 1'b1;
    cycle(tag);
    cnt_clr = 1'b0;
  endtask

  task automatic stream(input logic [15:0] bits, input int n, input string tag);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) bit_in(v[i], tag);
  endtask

  initial begin
    rst = 1'b0; x = 1'b0; x_valid = 1'b0; overlap = 1'b0;
    pat_load = 1'b0; cnt_clr = 1'b0; pat_in = '0; pat_len = '0;
    model_reset();
    #12;
    chk("rst/out_a", 32'(ifa.out), 32'd0);
    chk("rst/cnt_a", 32'(ifa.match_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Non-overlapping 1011 over 1,0,1,1,0,1,1
    overlap = 1'b0;
    load(5'b01011, 3'd4, "ld1011");
    stream(16'b1011011, 7, "nonovl");
    chk("nonovl/total", 32'(ifa.match_cnt), 32'd1);

    // Same stream with overlap
    clear("clr1");
    overlap = 1'b1;
    load(5'b01011, 3'd4, "ld1011b");
    stream(16'b1011011, 7, "ovl");
    chk("ovl/total", 32'(ifa.match_cnt), 32'd2);

    // Full-width 10110 via clamped length 0 and 7
    overlap = 1'b0;
    load(5'b10110, 3'd0, "ld_len0");
    stream(16'b10110, 5, "lat0");
    load(5'b10110, 3'd7, "ld_len7");
    stream(16'b10110, 5, "lat7");

    // Bits before a reload are discarded
    bit_in(1'b1, "pre1"); bit_in(1'b0, "pre0");
    load(5'b00011, 3'd3, "ld011");
    stream(16'b011, 3, "post011");

    // x_valid gaps inside a pattern
    bit_in(1'b0, "g0"); gap("gap1"); gap("gap2");
    bit_in(1'b1, "g1"); gap("gap3"); bit_in(1'b1, "g2");

    // Load strobe wins over a same-cycle sample
    bit_in(1'b0, "p0"); bit_in(1'b1, "p1");
    load(5'b00011, 3'd3, "ld_prio");
    bit_in(1'b1, "after_ld");

    // Saturation of the 2-bit counter and clear-vs-match priority
    clear("clr2");
    overlap = 1'b1;
    load(5'b00011, 3'd2, "ld11");
    stream(16'b111111, 6, "sat");
    chk("sat/cnt_c", 32'(ifc.match_cnt), 32'd3);
    x = 1'b1; x_valid = 1'b1; cnt_clr = 1'b1;
    cycle("clr_win");
    x_valid = 1'b0; cnt_clr = 1'b0;
    chk("clr_win/cnt_a", 32'(ifa.match_cnt), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      x        = 1'($urandom_range(1));
      x_valid  = ($urandom_range(3) != 0);
      pat_load = ($urandom_range(24) == 0);
      pat_in   = 5'($urandom);
      pat_len  = 3'($urandom_range(7));
      cnt_clr  = ($urandom_range(40) == 0);
      if ($urandom_range(15) == 0) overlap = ~overlap;
      if (i < 200 && pat_load) pat_len = 3'($urandom_range(3) + 1);
      cycle("rand");
    end
    x_valid = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;

    // Reset mid-pattern
    overlap = 1'b0;
    load(5'b01011, 3'd4, "ld_rst");
    stream(16'b101, 3, "pre_rst");
    rst = 1'b0;
    #1;
    chk("inrst/out_a", 32'(ifa.out), 32'd0);
    chk("inrst/out_b", 32'(ifb.out), 32'd0);
    chk("inrst/cnt_a", 32'(ifa.match_cnt), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bit_in(1'b1, "post_rst");
    chk("post_rst/cnt", 32'(ifa.match_cnt), 32'd0);
    stream(16'b0110, 4, "defpat");
    chk("defpat/cnt", 32'(ifa.match_cnt), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have parameter PAT_W, default 5, meaning maximum pattern length in bits (2..16).
REQ-002 The block SHALL have parameter DEF_PAT, default 5'b10110, meaning the pattern loaded at reset.
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning match counter width.
REQ-004 The block SHALL have parameter MEALY, default 0, meaning 1 = combinational match output, 0 = registered output.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port x, input, 1, serial data bit.
REQ-008 The block SHALL have port x_valid, input, 1, qualifying x; a sample is taken only when high.
REQ-009 The block SHALL have port overlap, input, 1, where 1 = overlapping detection and 0 = non-overlapping.
REQ-010 The block SHALL have port pat_load, input, 1, a load strobe for pat_in/pat_len.
REQ-011 The block SHALL have port pat_in, input, PAT_W, the new pattern (LSB = most recent bit).
REQ-012 The block SHALL have port pat_len, input, $clog2(PAT_W+1), the new active pattern length.
REQ-013 The block SHALL have port cnt_clr, input, 1, a synchronous match counter clear.
REQ-014 The block SHALL have port out, output, 1, a one-sample match pulse.
REQ-015 The block SHALL have port match_cnt, output, CNT_W, a saturating count of matches.

Function
REQ-016 On each accepted sample, the window SHALL shift: win <= {win[PAT_W-2:0], x}.
REQ-017 On each accepted sample, fill SHALL become min(fill+1, PAT_W).
REQ-018 A match SHALL be declared when all of the following hold:
- x_valid = 1;
- pat_load = 0;
- the post-shift fill >= len;
- the low len bits of the post-shift window equal the low len bits of the pattern.
REQ-019 In MEALY=1, out SHALL equal the match condition combinationally, in the same cycle as the final bit.
REQ-020 In MEALY=0, out SHALL be registered: high for exactly one cycle, on the edge after the matching sample.
REQ-021 In MEALY=0, out SHALL be low in any cycle that does not follow a matching sample.
REQ-022 With overlap=0, a match SHALL clear fill to 0, so no bit of a matched pattern contributes to the next match.
REQ-023 With overlap=1, a match SHALL NOT modify fill; shared suffix bits SHALL contribute to subsequent matches.
REQ-024 With x_valid=0, win, fill and match_cnt SHALL hold, and no match SHALL be declared.
REQ-025 When pat_load=1, the block SHALL capture pat_in and pat_len and clear fill to 0.
REQ-026 When pat_load=1, the same-cycle x sample SHALL be discarded; pat_load has priority over x_valid.
REQ-027 A pat_len of 0 or greater than PAT_W SHALL be clamped to PAT_W on load.
REQ-028 A pattern that changes mid-stream SHALL require len fresh samples before the next match.
REQ-029 match_cnt SHALL increment by 1 per match and saturate at 2^CNT_W-1, with no wrap.
REQ-030 cnt_clr SHALL force match_cnt to 0 and SHALL win over a simultaneous match; out is unaffected.
REQ-031 A change of overlap SHALL take effect from the next accepted sample and SHALL NOT alter win or fill.

Reset
REQ-032 On rst low, asynchronously, the block SHALL set:
- win = 0, fill = 0;
- pattern = DEF_PAT, len = PAT_W;
- out = 0 (both modes), match_cnt = 0.
REQ-033 Reset asserted mid-pattern SHALL discard the partial match; no out pulse SHALL appear during or after reset for bits sampled before it.
REQ-034 The first sample SHALL be accepted on the first rising clk edge after rst deasserts.

Structure
REQ-035 Shared package seq_det_pkg SHALL hold the default pattern/length constants and the overlap-mode encoding constants.
REQ-036 The saturating counter with clear priority SHALL be a sub-module named sat_counter, parameterised by CNT_W.
REQ-037 The match/window datapath SHALL remain in seq_detector_param; no further sub-modules.

Verification
REQ-038 Non-overlap: PAT_W=4, pattern 1011, len 4, overlap=0, stream 1,0,1,1,0,1,1 -> one match at bit 4; match_cnt=1.
REQ-039 Overlap: same stream with overlap=1 -> matches at bits 4 and 7; match_cnt=2.
REQ-040 Latency: pattern 10110 -> out high during bit-5 cycle with MEALY=1, and the cycle after with MEALY=0.
REQ-041 Reload and gaps:
- pat_load of 011 (len 3) after bits 1,0 -> those bits ignored; next 0,1,1 -> match_cnt +1;
- x_valid low gaps inside the pattern -> match still detected.
REQ-042 Saturation: CNT_W=2, 5 matches -> match_cnt=3; cnt_clr together with a match -> match_cnt=0.
REQ-043 Reset: rst low after bits 1,0,1 of pattern 1011, then release and apply 1 -> no out; match_cnt=0; pattern=DEF_PAT.
